// File: rtl/calc_result_collector.sv
// calc_result_collector
//   Reassembles 16-bit results from the upstream calculator's byte stream and
//   queues them in a small first-word-fall-through FIFO.
//
//   A frame is a low byte (phase_in == LO_PHASE) followed by a high byte
//   (phase_in == HI_PHASE). Any other phase between them aborts the frame.
//   A high byte with no low byte before it is ignored.
//
// Parameters
//   DEPTH    FIFO entries; power of two, 2..16
//   LO_PHASE phase value that carries the result low byte
//   HI_PHASE phase value that carries the result high byte
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   byte_in    result byte stream
//   phase_in   upstream sequencing counter
//   out_data   head-of-FIFO result, 16'h0000 when empty
//   out_valid  FIFO non-empty
//   out_ready  consumer accept
//   level      FIFO occupancy
//   overflow   sticky: a completed result was dropped because the FIFO was full
//   clr_ovf    clears overflow (and drop_cnt when present)
//   drop_cnt   saturating count of dropped results
//              (present only with CALC_COLLECTOR_DROP_CNT_EN defined)
//   fsm_state  framing FSM state (0 = IDLE, 1 = HAVE_LO), for observation
//
// Handshake: a result transfers on every rising edge where out_valid and
//   out_ready are both high; out_ready is ignored while out_valid is low, and
//   out_data is held stable until the transfer happens.

module calc_result_collector #(
  parameter int       DEPTH    = 4,
  parameter logic [2:0] LO_PHASE = 3'd5,
  parameter logic [2:0] HI_PHASE = 3'd6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 byte_in,
  input  logic [2:0]                 phase_in,
  output logic [15:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clr_ovf,
`ifdef CALC_COLLECTOR_DROP_CNT_EN
  output logic [7:0]                 drop_cnt,
`endif
  output logic [0:0]                 fsm_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] HAVE_LO = 1'b1;

  logic [0:0]    state;
  logic [7:0]    lo_byte;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;

  logic push;
  logic pop;
  logic full;
  logic do_write;
  logic drop;

  assign push      = (state == HAVE_LO) && (phase_in == HI_PHASE);
  assign out_valid = (cnt != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (cnt == FULL_LVL);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_write  = push && (!full || pop);
  assign drop      = push && full && !pop;

  assign level     = cnt;
  assign fsm_state = state;
  assign out_data  = out_valid ? mem[rd_ptr] : 16'h0000;

  // Framing FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      lo_byte <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (phase_in == LO_PHASE) begin
            lo_byte <= byte_in;
            state   <= HAVE_LO;
          end
        end
        HAVE_LO: begin
          if (phase_in == LO_PHASE) begin
            lo_byte <= byte_in;
          end else begin
            // HI completes the frame; any other phase aborts it.
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is not reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= {byte_in, lo_byte};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (do_write && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !do_write) cnt <= cnt - 1'b1;
    end
  end

  // Set wins over clear when a drop coincides with clr_ovf.
  always_ff @(posedge clk) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

`ifdef CALC_COLLECTOR_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= 8'h00;
    end else if (clr_ovf) begin
      drop_cnt <= drop ? 8'h01 : 8'h00;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: doc/calc_result_collector.md
CALC_RESULT_COLLECTOR -- requirements
Module: calc_result_collector

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 Parameter LO_PHASE, default 3'd5, phase value on which byte_in carries the result low byte.
REQ-003 Parameter HI_PHASE, default 3'd6, phase value on which byte_in carries the result high byte.
REQ-004 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 Port byte_in, input, 8, result byte stream from the upstream calculator's bidirectional data port.
REQ-007 Port phase_in, input, 3, upstream 3-bit sequencing counter.
REQ-008 Port out_data, output, 16, head-of-FIFO result (first-word fall-through).
REQ-009 Port out_valid, output, 1, high when FIFO non-empty.
REQ-010 Port out_ready, input, 1, consumer accepts out_data when out_valid && out_ready.
REQ-011 Port level, output, $clog2(DEPTH)+1, current FIFO occupancy.
REQ-012 Port overflow, output, 1, sticky: a completed result was dropped because FIFO was full.
REQ-013 Port clr_ovf, input, 1, clears overflow (and drop_cnt when compiled in).

Function
REQ-014 Framing FSM has two states, IDLE and HAVE_LO, plus a 8-bit lo_byte register.
REQ-015 IDLE: phase_in==LO_PHASE -> capture byte_in into lo_byte, go HAVE_LO; any other phase -> stay IDLE, no push.
REQ-016 HAVE_LO: phase_in==HI_PHASE -> form result {byte_in, lo_byte}, request push, go IDLE.
REQ-017 HAVE_LO: phase_in==LO_PHASE -> recapture lo_byte, stay HAVE_LO.
REQ-018 HAVE_LO: any other phase -> discard lo_byte, go IDLE, no push (aborted frame).
REQ-019 A HI_PHASE byte seen in IDLE is ignored; no result is ever assembled from an unpaired high byte.
REQ-020 Push writes the FIFO on the same edge that sampled HI_PHASE; out_valid rises on the following cycle when FIFO was empty (one-cycle latency from HI sample to out_valid).
REQ-021 Pop occurs on each edge where out_valid && out_ready; out_data/out_valid then reflect the next entry or go low.
REQ-022 out_ready while out_valid==0 has no effect.
REQ-023 Push while full and no simultaneous pop: result dropped, FIFO unchanged, overflow set.
REQ-024 Push and pop on the same edge: both performed, level unchanged, including when full (no drop) and when level==1.
REQ-025 Read/write pointers wrap modulo DEPTH; level saturates never exceeds DEPTH and never underflows.
REQ-026 out_data equals 16'h0000 whenever out_valid==0.
REQ-027 clr_ovf clears overflow on the next edge; if a drop occurs on the same edge, overflow remains set (set wins).

Reset
REQ-028 On rising edge with rst_n==0: FSM IDLE, lo_byte 0, pointers 0, level 0, out_valid 0, out_data 0, overflow 0; FIFO storage contents need not be cleared.
REQ-029 Reset mid-frame (in HAVE_LO) discards the partial result; first output after reset requires a fresh LO then HI pair.
REQ-030 Reset has priority over push, pop and clr_ovf on the same edge.

Configuration
REQ-031 Macro CALC_COLLECTOR_DROP_CNT_EN defined: extra output drop_cnt, 8 bits, increments per dropped result, saturates at 8'hFF, cleared by reset and by clr_ovf (increment on same edge as clr_ovf yields 8'h01).
REQ-032 Macro undefined: drop_cnt port and counter absent; all other behaviour identical.

Verification
REQ-033 Phases 5,6 with bytes 8'h34,8'h12, out_ready=0 -> out_valid=1 one cycle after HI sample, out_data=16'h1234, level=1.
REQ-034 Four frames 16'h0001..16'h0004 then a fifth 16'h0005, out_ready=0, DEPTH=4 -> level=4, overflow=1, pops return 1,2,3,4 in order, drop_cnt=1 when enabled.
REQ-035 Full FIFO, out_ready=1 on the edge pushing 16'hBEEF -> no drop, overflow=0, level stays 4, BEEF emerges after the three older entries.
REQ-036 Phases 5 (8'hAA), 2, 6 (8'hBB) -> no push, out_valid stays 0; phase 6 alone from IDLE -> no push.
REQ-037 Phase 5 (8'h77), rst_n=0 one cycle, then phase 6 (8'h88) -> no output; then 5 (8'h11), 6 (8'h22) -> out_data=16'h2211.
REQ-038 Drop and clr_ovf on same edge -> overflow=1 after edge; clr_ovf alone next edge -> overflow=0.
